qspi_tx_serializer: RTL and testbench

- Downstream consumer of the TX sync_fifo in the QSPI controller.
- Pops 32-bit words that the AHB side has written into the FIFO, then shifts them out on the QSPI IO lines in single, dual or quad mode, generating SCK in SPI mode 0.
- Chip-select and the command/address phases belong to the upstream sequencer; this block handles only the write-data phase.

---
 rtl/qspi_pkg.sv | 18 +
 rtl/qspi_sck_gen.sv | 32 +++
 rtl/qspi_tx_serializer.sv | 110 +++++++++++
 tb/tb_qspi_tx_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// qspi_pkg: shared QSPI mode/state types, word size and io_oe masks for the TX/RX datapaths
package qspi_pkg;
  typedef enum logic [1:0] {QSPI_SINGLE = 2'b00, QSPI_DUAL = 2'b01, QSPI_QUAD = 2'b10} qspi_mode_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_DATA, S_SHIFT, S_DONE} qspi_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [3:0] OE_SINGLE = 4'b0001;
  localparam logic [3:0] OE_DUAL = 4'b0011;
  localparam logic [3:0] OE_QUAD = 4'b1111;
  function automatic qspi_mode_t to_mode(input logic [1:0] m);
    return m == 2'b10 ? QSPI_QUAD : m == 2'b01 ? QSPI_DUAL : QSPI_SINGLE;
  endfunction
  function automatic logic [3:0] oe_mask(input qspi_mode_t m);
    return m == QSPI_QUAD ? OE_QUAD : m == QSPI_DUAL ? OE_DUAL : OE_SINGLE;
  endfunction
  function automatic logic [3:0] lead_bits(input qspi_mode_t m, input logic [31:0] s);
    return m == QSPI_QUAD ? s[31:28] : m == QSPI_DUAL ? {2'b00, s[31:30]} : {3'b000, s[31]};
  endfunction
endpackage

// File: rtl/qspi_sck_gen.sv
// qspi_sck_gen: mode-0 SCK divider (half-period clk_div+1); in clk,rst,enable,clk_div / out sck,rise_pulse,fall_pulse
module qspi_sck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             sck,
  output logic             rise_pulse,
  output logic             fall_pulse
);
  logic [DIV_W-1:0] cnt;
  logic tc;
  assign tc = enable && cnt == clk_div;
  assign rise_pulse = tc && !sck;
  assign fall_pulse = tc && sck;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/qspi_tx_serializer.sv
// qspi_tx_serializer: pops FIFO words and shifts them out single/dual/quad with mode-0 SCK; ctrl start/abort/byte_count/mode/clk_div, fifo rd_en/rd_data/empty, out sck/io_out/io_oe/busy/done/stall
module qspi_tx_serializer
  import qspi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      byte_count,
  input  logic [1:0]            mode,
  input  logic [DIV_W-1:0]      clk_div,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  sck,
  output logic [3:0]            io_out,
  output logic [3:0]            io_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  stall
);
  qspi_state_t state;
  qspi_mode_t mode_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] rem;
  logic [DATA_WIDTH-1:0] sreg, sreg_next, word_swap;
  logic [5:0] beats, word_beats;
  logic [2:0] word_bytes;
  logic rise, fall;
  // lane 0 goes out first, so byte-swap on load and always shift out of the MSB end
  assign word_swap = {fifo_rd_data[7:0], fifo_rd_data[15:8], fifo_rd_data[23:16], fifo_rd_data[31:24]};
  assign word_bytes = rem >= LEN_W'(BYTES_PER_WORD) ? 3'd4 : rem[2:0];
  assign word_beats = mode_q == QSPI_QUAD ? {2'b00, word_bytes, 1'b0} :
                      mode_q == QSPI_DUAL ? {1'b0, word_bytes, 2'b00} : {word_bytes, 3'b000};
  assign sreg_next = mode_q == QSPI_QUAD ? sreg << 4 : mode_q == QSPI_DUAL ? sreg << 2 : sreg << 1;
  assign fifo_rd_en = state == S_FETCH && !fifo_empty && !abort;
  assign stall = state == S_FETCH && fifo_empty;
  qspi_sck_gen #(.DIV_W(DIV_W)) u_sck (
    .clk       (clk),
    .rst       (rst),
    .enable    (state == S_SHIFT && !abort),
    .clk_div   (div_q),
    .sck       (sck),
    .rise_pulse(rise),
    .fall_pulse(fall)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      mode_q <= QSPI_SINGLE;
      div_q <= '0;
      rem <= '0;
      sreg <= '0;
      beats <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      io_oe <= '0;
      io_out <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      io_oe <= '0;
      io_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_q <= to_mode(mode);
          div_q <= clk_div;
          rem <= byte_count;
          busy <= 1'b1;
          io_oe <= oe_mask(to_mode(mode));
          state <= byte_count == '0 ? S_DONE : S_FETCH;
          done <= byte_count == '0;
        end
        S_FETCH: if (!fifo_empty) state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          sreg <= word_swap;
          io_out <= lead_bits(mode_q, word_swap);
          rem <= rem - LEN_W'(word_bytes);
          beats <= word_beats;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (rise) beats <= beats - 6'd1;
          // beats reaches zero after the word's last rise; the following fall ends the word
          if (fall) begin
            sreg <= sreg_next;
            io_out <= beats == '0 ? 4'b0000 : lead_bits(mode_q, sreg_next);
            if (beats == '0) begin
              state <= rem != '0 ? S_FETCH : S_DONE;
              done <= rem == '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
          io_oe <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_tx_serializer.sv
// tb_qspi_tx_serializer: table, directed and random checks of the QSPI TX serializer against a byte/bit-level model
module tb_qspi_tx_serializer;
  logic clk = 1'b0;
  logic rst, start, abort, fifo_empty, fifo_rd_en;
  logic [15:0] byte_count;
  logic [1:0] mode;
  logic [7:0] clk_div;
  logic [31:0] fifo_rd_data = '0;
  logic sck, busy, done, stall;
  logic [3:0] io_out, io_oe;
  int checks = 0, failures = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] cur_words[$];
  logic [3:0] exp_v[$];
  logic [3:0] rise_val[$];
  logic [3:0] rise_oe[$];
  int rise_cyc[$];
  int cyc = 0, rises, pops, bad_pop, dones, done_cyc, fall_cyc, start_cyc, stall_cycles, stall_sck;
  logic sck_prev = 1'b0, rd_prev = 1'b0, post_busy, post_sck;
  logic [3:0] post_oe;
  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int n;
    logic [1:0] m;
    int div;
    int exp_rises;
    int exp_pops;
  } vec_t;
  vec_t tbl[6];

  qspi_tx_serializer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .byte_count(byte_count),
    .mode(mode), .clk_div(clk_div), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .sck(sck), .io_out(io_out), .io_oe(io_oe), .busy(busy),
    .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  initial fifo_empty = 1'b1;
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    fifo_empty <= fifo_q.size() == 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (sck && !sck_prev) begin
      rises++;
      rise_val.push_back(io_out);
      rise_oe.push_back(io_oe);
      rise_cyc.push_back(cyc);
    end
    if (!sck && sck_prev) fall_cyc = cyc;
    if (fifo_rd_en) begin
      pops++;
      if (fifo_empty || rd_prev) bad_pop++;
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (cyc == done_cyc + 1) begin
      post_busy = busy;
      post_oe = io_oe;
      post_sck = sck;
    end
    if (stall) begin
      stall_cycles++;
      if (sck) stall_sck++;
    end
    sck_prev = sck;
    rd_prev = fifo_rd_en;
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    rises = 0; pops = 0; bad_pop = 0; dones = 0; stall_cycles = 0; stall_sck = 0;
    done_cyc = -100; fall_cyc = -100; start_cyc = -100;
    post_busy = 1'b1; post_oe = 4'hf; post_sck = 1'b1;
    rise_val.delete(); rise_oe.delete(); rise_cyc.delete();
  endtask

  task automatic push_words(input int np);
    for (int i = 0; i < np; i++) wr_q.push_back(cur_words[i]);
  endtask

  task automatic xfer(input string nm, input int n, input logic [1:0] m, input int div, input int delay);
    int np, w, wpw, t, per_err;
    logic [3:0] oe;
    logic [7:0] b;
    np = (n + 3) / 4;
    w = m == 2'd2 ? 4 : m == 2'd1 ? 2 : 1;
    wpw = 32 / w;
    oe = m == 2'd2 ? 4'hf : m == 2'd1 ? 4'h3 : 4'h1;
    exp_v.delete();
    for (int k = 0; k < n; k++) begin
      b = 8'((cur_words[k / 4] >> (8 * (k % 4))) & 32'hff);
      for (int g = 0; g < 8 / w; g++) exp_v.push_back(4'((b >> (8 - w * (g + 1))) & ((1 << w) - 1)));
    end
    clear_mon();
    if (delay == 0) begin
      push_words(np);
      repeat (2) tick();
    end
    start = 1'b1; byte_count = 16'(n); mode = m; clk_div = 8'(div);
    tick();
    start = 1'b0;
    if (delay > 0) begin
      repeat (delay) tick();
      push_words(np);
    end
    t = 0;
    while (dones == 0 && t < 5000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk({nm, " done_count"}, dones, 1);
    chk({nm, " rises"}, rises, exp_v.size());
    chk({nm, " pops"}, pops, np);
    chk({nm, " bad_pop"}, bad_pop, 0);
    chk({nm, " stall_sck"}, stall_sck, 0);
    for (int i = 0; i < rises && i < exp_v.size(); i++) begin
      chk($sformatf("%s io_out[%0d]", nm, i), rise_val[i], exp_v[i]);
      chk($sformatf("%s io_oe[%0d]", nm, i), rise_oe[i], oe);
    end
    per_err = 0;
    for (int i = 1; i < rises; i++)
      if (i / wpw == (i - 1) / wpw && rise_cyc[i] - rise_cyc[i - 1] != 2 * (div + 1)) per_err++;
    chk({nm, " sck_period_err"}, per_err, 0);
    chk({nm, " done_cyc"}, done_cyc, n == 0 ? start_cyc + 1 : fall_cyc);
    chk({nm, " post_busy"}, post_busy, 0);
    chk({nm, " post_oe"}, post_oe, 0);
    chk({nm, " post_sck"}, post_sck, 0);
  endtask

  initial begin
    int t;
    tbl[0] = '{32'hA1B2C3D4, 32'h0, 4, 2'd2, 0, 8, 1};
    tbl[1] = '{32'hA1B2C3D4, 32'h0, 4, 2'd0, 1, 32, 1};
    tbl[2] = '{32'h11223344, 32'h0000AA55, 6, 2'd2, 0, 12, 2};
    tbl[3] = '{32'h00C0FFEE, 32'h0, 3, 2'd1, 2, 12, 1};
    tbl[4] = '{32'h12345678, 32'h0, 2, 2'd3, 0, 16, 1};
    tbl[5] = '{32'h0, 32'h0, 0, 2'd2, 0, 0, 0};
    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_count = '0; mode = '0; clk_div = '0;
    repeat (3) tick();
    chk("reset sck", sck, 0);
    chk("reset io_out", io_out, 0);
    chk("reset io_oe", io_oe, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset stall", stall, 0);
    chk("reset rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      cur_words.delete();
      cur_words.push_back(tbl[i].w0);
      cur_words.push_back(tbl[i].w1);
      xfer($sformatf("tbl%0d", i), tbl[i].n, tbl[i].m, tbl[i].div, 0);
      chk($sformatf("tbl%0d table_rises", i), rises, tbl[i].exp_rises);
      chk($sformatf("tbl%0d table_pops", i), pops, tbl[i].exp_pops);
    end

    cur_words.delete();
    cur_words.push_back(32'hCAFEBABE);
    xfer("stall", 4, 2'd2, 0, 20);
    chk("stall cycles>=18", stall_cycles >= 18, 1);

    cur_words.delete();
    cur_words.push_back(32'hA1B2C3D4);
    cur_words.push_back(32'h55667788);
    clear_mon();
    push_words(2);
    repeat (2) tick();
    start = 1'b1; byte_count = 16'd8; mode = 2'd2; clk_div = 8'd1;
    tick();
    start = 1'b0;
    t = 0;
    while (rises < 5 && t < 500) begin
      tick();
      t++;
    end
    chk("abort reached byte2", rises >= 5, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort sck", sck, 0);
    chk("abort io_oe", io_oe, 0);
    repeat (10) tick();
    chk("abort no_done", dones, 0);
    chk("abort pops", pops, 1);
    chk("abort sck_idle", sck, 0);
    fifo_q.delete();
    repeat (2) tick();
    cur_words.delete();
    cur_words.push_back(32'hA1B2C3D4);
    xfer("after_abort", 4, 2'd2, 0, 0);

    cur_words.delete();
    cur_words.push_back(32'hDEADBEEF);
    cur_words.push_back(32'h01234567);
    clear_mon();
    push_words(2);
    repeat (2) tick();
    start = 1'b1; byte_count = 16'd8; mode = 2'd0; clk_div = 8'd0;
    tick();
    start = 1'b0;
    repeat (12) tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst sck", sck, 0);
    chk("midrst busy", busy, 0);
    chk("midrst io_oe", io_oe, 0);
    chk("midrst io_out", io_out, 0);
    tick();
    rst = 1'b0;
    fifo_q.delete();
    repeat (3) tick();

    for (int r = 0; r < 8; r++) begin
      int n;
      cur_words.delete();
      for (int i = 0; i < 3; i++) cur_words.push_back($urandom);
      n = $urandom_range(1, 10);
      xfer($sformatf("rnd%0d", r), n, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 1) * $urandom_range(1, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
